// File: rtl/fpnew_noncomp_resp.sv
//------------------------------------------------------------------------------
// fpnew_noncomp_resp
//
// Response buffer for the non-computational FP unit. Each incoming result is
// formatted to the core writeback width as it enters a 2-entry FIFO:
// classifications are zero-extended and carry no flags, while other results
// are widened by replicating extension_bit_i above the FP value. The head entry
// is presented to the core with a valid/ready handshake. Popped status flags
// accumulate into a sticky fflags register that a flush does not disturb.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   in_valid_i/o_ready unit-side handshake (in_ready_o depends on state only)
//   result_i, status_i raw FP result and {NV,DZ,OF,UF,NX} flags
//   extension_bit_i    fill value for bits XLEN-1:WIDTH
//   class_mask_i       classification mask, used when is_class_i=1
//   tag_i              operation tag carried alongside the result
//   flush_i            drop buffered and incoming results
//   out_valid_o/i_ready core-side handshake
//   result_o, status_o, tag_o  head entry of the FIFO
//   fflags_o, fflags_clr_i     sticky flags and their clear
//   busy_o             at least one response is buffered
//------------------------------------------------------------------------------
module fpnew_noncomp_resp #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned XLEN      = 64,
   parameter int unsigned TAG_WIDTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     result_i,
   input  logic [4:0]           status_i,
   input  logic                 extension_bit_i,
   input  logic [9:0]           class_mask_i,
   input  logic                 is_class_i,
   input  logic [TAG_WIDTH-1:0] tag_i,
   input  logic                 flush_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [XLEN-1:0]      result_o,
   output logic [4:0]           status_o,
   output logic [TAG_WIDTH-1:0] tag_o,
   output logic [4:0]           fflags_o,
   input  logic                 fflags_clr_i,
   output logic                 busy_o
);

   // Widen a unit result to the writeback width.
   function automatic logic [XLEN-1:0] fmt_result(
      input logic             is_class,
      input logic [9:0]       mask,
      input logic [WIDTH-1:0] res,
      input logic             ext
   );
      logic [XLEN-1:0] v;
      if (is_class) begin
         v       = '0;
         v[9:0]  = mask;
      end else begin
         v              = {XLEN{ext}};
         v[WIDTH-1:0]   = res;
      end
      return v;
   endfunction

   logic [1:0]           r_count;
   logic                 r_rd_ptr;
   logic                 r_wr_ptr;
   logic [XLEN-1:0]      r_data   [2];
   logic [4:0]           r_status [2];
   logic [TAG_WIDTH-1:0] r_tag    [2];
   logic [4:0]           r_fflags;

   logic                 w_push;
   logic                 w_pop;
   logic [1:0]           w_count_next;
   logic [XLEN-1:0]      w_fmt_result;
   logic [4:0]           w_fmt_status;
   logic [4:0]           w_fflags_next;

   assign in_ready_o  = (r_count != 2'd2);
   assign out_valid_o = (r_count != 2'd0);
   assign busy_o      = (r_count != 2'd0);
   assign result_o    = r_data[r_rd_ptr];
   assign status_o    = r_status[r_rd_ptr];
   assign tag_o       = r_tag[r_rd_ptr];
   assign fflags_o    = r_fflags;

   // Flush suppresses both handshakes in the cycle it is asserted.
   assign w_push = in_valid_i & in_ready_o & ~flush_i;
   assign w_pop  = out_valid_o & out_ready_i & ~flush_i;

   // Format the incoming result; classifications never raise flags.
   always_comb begin
      w_fmt_result = fmt_result(is_class_i, class_mask_i, result_i, extension_bit_i);
      if (is_class_i) begin
         w_fmt_status = 5'd0;
      end else begin
         w_fmt_status = status_i;
      end
   end

   // Occupancy update; simultaneous push and pop leaves the count unchanged.
   always_comb begin
      w_count_next = r_count;
      if (flush_i) begin
         w_count_next = 2'd0;
      end else if (w_push && !w_pop) begin
         w_count_next = r_count + 2'd1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 2'd1;
      end else begin
         w_count_next = r_count;
      end
   end

   // Sticky flags: clear first, then OR in the flags of the popped entry so a
   // same-cycle clear and pop keeps exactly the popped flags.
   always_comb begin
      w_fflags_next = fflags_clr_i ? 5'd0 : r_fflags;
      if (w_pop) begin
         w_fflags_next = w_fflags_next | status_o;
      end else begin
         w_fflags_next = w_fflags_next;
      end
   end

   // Occupancy count and read/write pointers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count  <= 2'd0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
      end else if (flush_i) begin
         r_count  <= 2'd0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
      end else begin
         r_count <= w_count_next;
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
      end
   end

   // FIFO storage; written only on an accepted push so idle payload is ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 2; i++) begin
            r_data[i]   <= '0;
            r_status[i] <= 5'd0;
            r_tag[i]    <= '0;
         end
      end else if (w_push) begin
         r_data[r_wr_ptr]   <= w_fmt_result;
         r_status[r_wr_ptr] <= w_fmt_status;
         r_tag[r_wr_ptr]    <= tag_i;
      end
   end

   // Sticky flag register; flush deliberately has no effect here.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fflags <= 5'd0;
      end else begin
         r_fflags <= w_fflags_next;
      end
   end

endmodule

// File: tb/tb_fpnew_noncomp_resp.sv
//------------------------------------------------------------------------------
// tb_fpnew_noncomp_resp
//
// Directed bench with a queue-based scoreboard: every push the bench expects
// to be accepted appends its formatted entry, every expected pop removes the
// head, and the DUT outputs are compared against the scoreboard each cycle.
//------------------------------------------------------------------------------
module tb_fpnew_noncomp_resp;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  st;
      logic [3:0]  tag;
   } ent_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] result_i;
   logic [4:0]  status_i;
   logic        extension_bit_i;
   logic [9:0]  class_mask_i;
   logic        is_class_i;
   logic [3:0]  tag_i;
   logic        flush_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [63:0] result_o;
   logic [4:0]  status_o;
   logic [3:0]  tag_o;
   logic [4:0]  fflags_o;
   logic        fflags_clr_i;
   logic        busy_o;

   ent_t        q[$];
   logic [4:0]  m_ff;
   int          n_pass  = 0;
   int          n_total = 0;

   fpnew_noncomp_resp dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .result_i        (result_i),
      .status_i        (status_i),
      .extension_bit_i (extension_bit_i),
      .class_mask_i    (class_mask_i),
      .is_class_i      (is_class_i),
      .tag_i           (tag_i),
      .flush_i         (flush_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .result_o        (result_o),
      .status_o        (status_o),
      .tag_o           (tag_o),
      .fflags_o        (fflags_o),
      .fflags_clr_i    (fflags_clr_i),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
   endtask

   function automatic logic [63:0] fmt(input logic cls, input logic [9:0] mask,
                                       input logic [31:0] res, input logic ext);
      if (cls) return {54'd0, mask};
      return {{32{ext}}, res};
   endfunction

   // Compare every observable output against the scoreboard.
   task automatic check_all(input string name);
      chk({name, ".out_valid"}, 64'(out_valid_o), 64'(q.size() != 0));
      chk({name, ".busy"},      64'(busy_o),      64'(q.size() != 0));
      chk({name, ".in_ready"},  64'(in_ready_o),  64'(q.size() != 2));
      chk({name, ".fflags"},    64'(fflags_o),    64'(m_ff));
      if (q.size() != 0) begin
         chk({name, ".result"}, result_o,        q[0].res);
         chk({name, ".status"}, 64'(status_o),   64'(q[0].st));
         chk({name, ".tag"},    64'(tag_o),      64'(q[0].tag));
      end
   endtask

   // One clock cycle: drive at the falling edge, update the model at the
   // rising edge, check at the next falling edge.
   task automatic cycle(input string name, input logic v, input logic [31:0] res,
                        input logic ext, input logic [4:0] st, input logic cls,
                        input logic [9:0] mask, input logic [3:0] tg,
                        input logic ordy, input logic fl, input logic clr);
      logic mpush, mpop;
      ent_t e;
      in_valid_i      = v;
      result_i        = res;
      extension_bit_i = ext;
      status_i        = st;
      is_class_i      = cls;
      class_mask_i    = mask;
      tag_i           = tg;
      out_ready_i     = ordy;
      flush_i         = fl;
      fflags_clr_i    = clr;
      mpush = v && (q.size() != 2) && !fl;
      mpop  = (q.size() != 0) && ordy && !fl;
      e.res = fmt(cls, mask, res, ext);
      e.st  = cls ? 5'd0 : st;
      e.tag = tg;
      @(posedge clk_i);
      m_ff = (clr ? 5'd0 : m_ff) | (mpop ? q[0].st : 5'd0);
      if (fl) begin
         q.delete();
      end else begin
         if (mpop)  void'(q.pop_front());
         if (mpush) q.push_back(e);
      end
      @(negedge clk_i);
      check_all(name);
   endtask

   task automatic idle(input string name, input logic ordy);
      cycle(name, 1'b0, $urandom(), 1'b1, 5'h1F, 1'b0, 10'h3FF, 4'hF, ordy, 1'b0, 1'b0);
   endtask

   task automatic push(input string name, input logic [4:0] st, input logic [3:0] tg,
                       input logic ordy);
      cycle(name, 1'b1, $urandom(), tg[0], st, 1'b0, 10'd0, tg, ordy, 1'b0, 1'b0);
   endtask

   initial begin
      q.delete();
      m_ff            = 5'd0;
      rst_ni          = 1'b0;
      in_valid_i      = 1'b0;
      result_i        = 32'd0;
      status_i        = 5'd0;
      extension_bit_i = 1'b0;
      class_mask_i    = 10'd0;
      is_class_i      = 1'b0;
      tag_i           = 4'd0;
      flush_i         = 1'b0;
      out_ready_i     = 1'b0;
      fflags_clr_i    = 1'b0;

      // Reset values, both during and after reset.
      #2;
      chk("rst.out_valid", 64'(out_valid_o), 64'd0);
      chk("rst.in_ready",  64'(in_ready_o),  64'd1);
      chk("rst.result",    result_o,         64'd0);
      chk("rst.tag",       64'(tag_o),       64'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check_all("rst_rel");
      chk("rst_rel.status", 64'(status_o), 64'd0);

      // Single pass-through.
      cycle("pass", 1'b1, 32'h3F80_0000, 1'b1, 5'b00001, 1'b0, 10'd0, 4'd3, 1'b1, 1'b0, 1'b0);
      chk("pass.result_const", result_o, 64'hFFFF_FFFF_3F80_0000);
      chk("pass.tag_const",    64'(tag_o), 64'd3);
      idle("pass_pop", 1'b1);
      chk("pass.fflags_const", 64'(fflags_o), 64'h01);
      chk("pass.busy_const",   64'(busy_o),   64'd0);

      // Classification: mask zero-extended, flags suppressed.
      cycle("cls", 1'b1, 32'hDEAD_BEEF, 1'b1, 5'b10000, 1'b1, 10'h040, 4'd5, 1'b0, 1'b0, 1'b0);
      chk("cls.result_const", result_o, 64'h0000_0000_0000_0040);
      chk("cls.status_const", 64'(status_o), 64'd0);
      idle("cls_pop", 1'b1);
      chk("cls.fflags_const", 64'(fflags_o), 64'h01);

      // Backpressure and full.
      push("bp1", 5'b00100, 4'd1, 1'b0);
      push("bp2", 5'b01000, 4'd2, 1'b0);
      chk("bp.in_ready_full", 64'(in_ready_o), 64'd0);
      push("bp3_ignored", 5'b10000, 4'd9, 1'b0);
      chk("bp.tag_hold", 64'(tag_o), 64'd1);
      idle("bp_pop1", 1'b1);
      chk("bp.tag2", 64'(tag_o), 64'd2);
      idle("bp_pop2", 1'b1);
      chk("bp.fflags", 64'(fflags_o), 64'h0D);

      // Simultaneous push and pop at count 1.
      push("sim4", 5'd0, 4'd4, 1'b1);
      push("sim5", 5'd0, 4'd5, 1'b1);
      chk("sim.tag5", 64'(tag_o), 64'd5);
      push("sim6", 5'd0, 4'd6, 1'b1);
      push("sim7", 5'd0, 4'd7, 1'b1);
      chk("sim.tag7", 64'(tag_o), 64'd7);
      chk("sim.in_ready", 64'(in_ready_o), 64'd1);
      idle("sim_drain", 1'b1);

      // Same-cycle clear and pop keeps only the popped flags.
      push("clr_push", 5'b10000, 4'd10, 1'b0);
      cycle("clr_pop", 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 10'd0, 4'd0, 1'b1, 1'b0, 1'b1);
      chk("clr.fflags", 64'(fflags_o), 64'h10);
      push("nx_push", 5'b00001, 4'd11, 1'b1);
      idle("nx_pop", 1'b1);
      chk("nx.fflags", 64'(fflags_o), 64'h11);

      // Flush while full with a valid input in the same cycle.
      push("fl_a", 5'b00010, 4'd12, 1'b0);
      push("fl_b", 5'b00010, 4'd13, 1'b0);
      cycle("flush", 1'b1, 32'h1234_5678, 1'b0, 5'b00100, 1'b0, 10'd0, 4'd14, 1'b1, 1'b1, 1'b0);
      chk("flush.out_valid", 64'(out_valid_o), 64'd0);
      chk("flush.fflags",    64'(fflags_o),    64'h11);
      idle("flush_after", 1'b1);

      // Asynchronous reset mid-cycle while full.
      push("rs_a", 5'b00010, 4'd1, 1'b0);
      push("rs_b", 5'b00010, 4'd2, 1'b0);
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      q.delete();
      m_ff = 5'd0;
      chk("arst.out_valid", 64'(out_valid_o), 64'd0);
      chk("arst.busy",      64'(busy_o),      64'd0);
      chk("arst.fflags",    64'(fflags_o),    64'd0);
      chk("arst.result",    result_o,         64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check_all("arst_rel");

      // Payload with in_valid_i=0 is ignored; normal operation resumes.
      idle("dontcare", 1'b1);
      cycle("resume", 1'b1, 32'h4000_0000, 1'b0, 5'b01000, 1'b0, 10'd0, 4'd8, 1'b0, 1'b0, 1'b0);
      idle("resume_pop", 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
